// File: rtl/char_console_writer.sv
// Character console writer: turns a valid/ready ASCII stream into frame buffer writes,
// tracking a text cursor and handling CR/LF/BS/FF, line wrap, hardware scroll and clear.
module char_console_writer #(
  parameter int unsigned H_CHARS    = 100,
  parameter int unsigned V_CHARS    = 75,
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  axi4clk,
  input  logic                  reset_axi,
  input  logic                  char_valid,
  output logic                  char_ready,
  input  logic [7:0]            char_code,
  input  logic [8:0]            char_color,
  output logic [ADDR_WIDTH-1:0] processor_addr,
  output logic [15:0]           processor_din,
  input  logic [15:0]           processor_dout,
  output logic                  processor_we,
  output logic [6:0]            cursor_col,
  output logic [6:0]            cursor_row,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] HStep      = ADDR_WIDTH'(H_CHARS);
  localparam logic [ADDR_WIDTH-1:0] ScrollLast = ADDR_WIDTH'((V_CHARS - 1) * H_CHARS - 1);
  localparam logic [ADDR_WIDTH-1:0] ScreenLast = ADDR_WIDTH'(V_CHARS * H_CHARS - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne    = ADDR_WIDTH'(1);
  localparam logic [6:0]            ColLast    = 7'(H_CHARS - 1);
  localparam logic [6:0]            RowLast    = 7'(V_CHARS - 1);
  localparam logic [15:0]           Blank      = 16'h0020;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StScrollRd,
    StScrollWr,
    StClearRow,
    StClearAll
  } state_e;

  state_e                state_q, state_d;
  logic [6:0]            col_q, col_d;
  logic [6:0]            row_q, row_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]            code_q, code_d;
  logic [8:0]            color_q, color_d;
  logic                  do_lf;

  always_ff @(posedge axi4clk) begin
    if (reset_axi) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    base_d         = base_q;
    idx_d          = idx_q;
    code_d         = code_q;
    color_d        = color_q;
    do_lf          = 1'b0;
    char_ready     = 1'b0;
    busy           = 1'b0;
    processor_we   = 1'b0;
    processor_addr = '0;
    processor_din  = '0;

    unique case (state_q)
      StIdle: begin
        char_ready = ~reset_axi;
        if (char_valid) begin
          state_d = StExec;
          code_d  = char_code;
          color_d = char_color;
        end
      end

      StExec: begin
        state_d = StIdle;
        if (code_q >= 8'h20 && code_q <= 8'h7E) begin
          processor_we   = 1'b1;
          processor_addr = base_q + ADDR_WIDTH'(col_q);
          processor_din  = {color_q, code_q[6:0]};
          if (col_q == ColLast) begin
            col_d = '0;
            do_lf = 1'b1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end else begin
          case (code_q)
            8'h0D: col_d = '0;
            8'h0A: do_lf = 1'b1;
            8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
            8'h0C: begin
              state_d = StClearAll;
              idx_d   = '0;
            end
            default: ;
          endcase
        end
        // Bottom row overflow scrolls instead of advancing; the cursor stays on the last row.
        if (do_lf) begin
          if (row_q != RowLast) begin
            row_d  = row_q + 7'd1;
            base_d = base_q + HStep;
          end else begin
            state_d = StScrollRd;
            idx_d   = '0;
          end
        end
      end

      StScrollRd: begin
        busy           = 1'b1;
        processor_addr = idx_q + HStep;
        state_d        = StScrollWr;
      end

      StScrollWr: begin
        busy           = 1'b1;
        processor_we   = 1'b1;
        processor_addr = idx_q;
        processor_din  = processor_dout;
        idx_d          = idx_q + AddrOne;
        // idx continues straight into the first word of the last row.
        if (idx_q == ScrollLast) state_d = StClearRow;
        else                     state_d = StScrollRd;
      end

      StClearRow, StClearAll: begin
        busy           = 1'b1;
        processor_we   = 1'b1;
        processor_addr = idx_q;
        processor_din  = Blank;
        idx_d          = idx_q + AddrOne;
        if (idx_q == ScreenLast) begin
          state_d = StIdle;
          if (state_q == StClearAll) begin
            col_d  = '0;
            row_d  = '0;
            base_d = '0;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule
